stream_out_fifo: RTL
====================

# stream_out_fifo

Per-output elastic buffer placed directly downstream of one `stream_xbar` master port. It absorbs back-pressure from the consumer so that a stalled sink does not hold the crossbar grant longer than necessary. It stores the beat payload (`data`, `id`, `last`) in a first-word-fall-through FIFO. An optional packet mode releases beats only once a complete packet is held.

## Interface

Parameters:
- `T_DATA_WIDTH`, 8: beat data width; matches the crossbar.
- `S_DATA_COUNT`, 2: number of crossbar slave ports; sets the ID width.
- `DEPTH`, 4: number of stored beats; any integer ≥ 2.
- `T_ID___WIDTH`, localparam, `$clog2(S_DATA_COUNT)`.
- `CNT_WIDTH`, localparam, `$clog2(DEPTH+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_data_i`  in  T_DATA_WIDTH  beat data from the crossbar `m_data_o[k]`.
- `s_id_i`  in  T_ID___WIDTH  source ID from `m_id_o[k]`.
- `s_last_i`  in  1  end-of-packet flag.
- `s_valid_i`  in  1  beat valid.
- `s_ready_o`  out  1  FIFO can accept a beat; drives the crossbar `m_ready_i[k]`.
- `m_data_o`  out  T_DATA_WIDTH  head beat data.
- `m_id_o`  out  T_ID___WIDTH  head beat ID.
- `m_last_o`  out  1  head beat last.
- `m_valid_o`  out  1  head beat available.
- `m_ready_i`  in  1  consumer accepts the head beat.
- `count_o`  out  CNT_WIDTH  number of stored beats.

## Operation

- **Push:** occurs when `s_valid_i && s_ready_o`. The beat is written to `mem[wr_ptr]` and `wr_ptr` advances.
- **Pop:** occurs when `m_valid_o && m_ready_i`. `rd_ptr` advances.
- **Pointer wrap:** pointers wrap from `DEPTH-1` to 0 explicitly, with no power-of-two assumption.
- **Count:** `count` is incremented on push only, decremented on pop only, and unchanged on simultaneous push and pop.
- **Ready:** `s_ready_o = (count != DEPTH)`. It depends only on registered state, with no combinational path from `m_ready_i`.
- **Valid:** `m_valid_o = (count != 0)`, gated by the packet-mode condition when that mode is compiled in.
- **Head outputs:** `m_data_o`, `m_id_o` and `m_last_o` are read combinationally from `mem[rd_ptr]`. They are forced to 0 whenever `m_valid_o` is 0.
- **AXI-Stream rules:** a beat held with `m_valid_o` high stays stable until it is popped. `m_valid_o` never drops without a pop.
- **Full:** when full, `s_ready_o` is 0, so no push is possible. A pop in that cycle raises `s_ready_o` in the next cycle.
- **Empty:** when empty, `m_valid_o` is 0. A push in that cycle shows the beat on `m_*` in the next cycle.
- **Reset mid-packet:** all pointers and counters clear. Stored beats are discarded, with no partial-packet recovery.

## Timing

- **Reset values:** `s_ready_o` = 1, `m_valid_o` = 0, `m_data_o`/`m_id_o`/`m_last_o` = 0, `count_o` = 0. The memory array is not reset.
- **Latency:** a beat pushed in cycle N is presented on `m_*` in cycle N+1 in the default mode. This is the minimum latency.
- **Throughput:** one beat per cycle in and out at any occupancy, except full (no push) or empty (no pop).
- **Count timing:** `count_o` updates on the edge after the push or pop.

## Configuration

- **Macro:** `STREAM_OUT_FIFO_PACKET_MODE_EN`.
- **Without the macro:** cut-through; `m_valid_o = (count != 0)`.
- **With the macro:** store-and-forward.
  - A registered counter `pkt_cnt`, of width CNT_WIDTH, counts complete packets held in the FIFO.
  - `pkt_cnt` increments on a push with `s_last_i` = 1 and decrements on a pop with `m_last_o` = 1; both in one cycle leave it unchanged.
  - `m_valid_o = (count != 0) && ((pkt_cnt != 0) || (count == DEPTH))`.
  - The full override forwards an oversized packet rather than deadlocking.
  - Latency from the `last` push to the first `m_valid_o` is 1 cycle.
  - `pkt_cnt` resets to 0.

## Structure

- **Shared package `stream_pkg`:** a packed beat struct `stream_beat_t` with fields `data`, `id`, `last`.
  - The struct is parameterised through package parameters, or through a width function reused by the crossbar.
  - The package also holds a common pointer-increment-with-wrap function.
- **Sub-module `stream_fifo_mem`:** storage array of `DEPTH` × beat, with synchronous write and asynchronous read.
- **Top level:** keeps pointers, counters and handshake logic in `stream_out_fifo`.

## Test plan

- **Reset:** hold `rst_n` = 0 for 3 cycles while `s_valid_i` = 1 → `s_ready_o` = 1, `m_valid_o` = 0, `m_*` = 0, `count_o` = 0 after release.
- **Fill and drain:** `DEPTH` = 4, `m_ready_i` = 0, push data 0x11..0x14 → `count_o` = 4 and `s_ready_o` = 0. Then `m_ready_i` = 1 → data 0x11, 0x12, 0x13, 0x14 pops on 4 consecutive cycles, and `s_ready_o` = 1 the cycle after the first pop.
- **Simultaneous push/pop:** at `count_o` = 2, push and pop in the same cycle → `count_o` stays 2 and ordering is preserved. `DEPTH` = 3 run: 10 beats pass with correct wrap of both pointers.
- **Empty pass-through:** push a single beat 0xA5 with `id` = 1 and `last` = 1 into an empty FIFO in cycle N → `m_valid_o` = 1 with 0xA5/1/1 in cycle N+1.
- **Packet mode, normal packet (macro defined):** push a 3-beat packet with `last` on beat 3 → `m_valid_o` stays 0 until the cycle after beat 3, then all 3 beats are emitted.
- **Packet mode, oversized packet and reset:**
  - Push a 5-beat packet into `DEPTH` = 4 → `m_valid_o` asserts once `count_o` = 4, and all 5 beats are delivered.
  - Reset mid-packet → `count_o` = 0, `pkt_cnt` = 0, `m_valid_o` = 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared stream definitions: beat payload layout and pointer helpers.
// Used by stream_out_fifo and the crossbar that feeds it.
package stream_pkg;

  localparam int unsigned STREAM_DATA_WIDTH = 8;
  localparam int unsigned STREAM_ID_WIDTH   = 1;

  // Reference beat layout at the default crossbar widths.
  typedef struct packed {
    logic [STREAM_DATA_WIDTH-1:0] data;
    logic [STREAM_ID_WIDTH-1:0]   id;
    logic                         last;
  } stream_beat_t;

  // Packed beat width for an arbitrary data/id width pair.
  function automatic int unsigned beat_width(input int unsigned data_w,
                                             input int unsigned id_w);
    return data_w + id_w + 1;
  endfunction

  // Pointer increment that wraps at depth-1; depth need not be a power of two.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Beat storage for stream_out_fifo: synchronous write, asynchronous read.
// Ports: clk; wr_en/wr_ptr/wr_data write port; rd_ptr/rd_data read port.
// The array is intentionally not reset.
module stream_fifo_mem #(
  parameter  int unsigned WIDTH     = 10,
  parameter  int unsigned DEPTH     = 4,
  localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [PTR_WIDTH-1:0] wr_ptr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [PTR_WIDTH-1:0] rd_ptr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/stream_out_fifo.sv
// Elastic first-word-fall-through buffer behind one crossbar master port.
// Ports: clk, rst_n (sync, active-low); s_* input beat stream with
// s_ready_o; m_* head beat stream with m_ready_i; count_o = stored beats.
// Optional store-and-forward: define STREAM_OUT_FIFO_PACKET_MODE_EN to hold
// beats until a complete packet is buffered (or the buffer is full).
module stream_out_fifo
  import stream_pkg::*;
#(
  parameter  int unsigned T_DATA_WIDTH = 8,
  parameter  int unsigned S_DATA_COUNT = 2,
  parameter  int unsigned DEPTH        = 4,
  localparam int unsigned T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int unsigned CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic [T_ID___WIDTH-1:0] s_id_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic [T_ID___WIDTH-1:0] m_id_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [CNT_WIDTH-1:0]    count_o
);

  localparam int unsigned PTR_WIDTH  = $clog2(DEPTH);
  localparam int unsigned BEAT_WIDTH = beat_width(T_DATA_WIDTH, T_ID___WIDTH);

  typedef struct packed {
    logic [T_DATA_WIDTH-1:0] data;
    logic [T_ID___WIDTH-1:0] id;
    logic                    last;
  } beat_t;

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  beat_t                wr_beat_c;
  beat_t                rd_beat_c;
  logic                 push_c;
  logic                 pop_c;
  logic                 release_c;

  assign wr_beat_c = '{data: s_data_i, id: s_id_i, last: s_last_i};

  stream_fifo_mem #(
    .WIDTH (BEAT_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_c),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_beat_c),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_beat_c)
  );

  // Handshakes depend only on registered occupancy, never on m_ready_i.
  assign s_ready_o = (count != CNT_WIDTH'(DEPTH));
  assign m_valid_o = (count != '0) && release_c;
  assign push_c    = s_valid_i && s_ready_o;
  assign pop_c     = m_valid_o && m_ready_i;

  // Head beat is zeroed whenever it is not being offered.
  assign m_data_o = m_valid_o ? rd_beat_c.data : '0;
  assign m_id_o   = m_valid_o ? rd_beat_c.id   : '0;
  assign m_last_o = m_valid_o ? rd_beat_c.last : 1'b0;
  assign count_o  = count;

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= PTR_WIDTH'(ptr_inc(32'(wr_ptr), DEPTH));
      if (pop_c)  rd_ptr <= PTR_WIDTH'(ptr_inc(32'(rd_ptr), DEPTH));
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef STREAM_OUT_FIFO_PACKET_MODE_EN
  // Complete packets held; a full buffer releases anyway so an oversized
  // packet cannot deadlock.
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic                 pkt_in_c;
  logic                 pkt_out_c;

  assign pkt_in_c  = push_c && s_last_i;
  assign pkt_out_c = pop_c && rd_beat_c.last;
  assign release_c = (pkt_cnt != '0) || (count == CNT_WIDTH'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else begin
      case ({pkt_in_c, pkt_out_c})
        2'b10:   pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
        2'b01:   pkt_cnt <= pkt_cnt - CNT_WIDTH'(1);
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end
`else
  assign release_c = 1'b1;
`endif

endmodule
